// File: rtl/checker_mode_ctrl.sv
// Initiator side of the checker mode interface: starts a mode engine, keeps the
// run alive, relays engine interrupts to the host and captures end/error status.
module checker_mode_ctrl #(
   parameter logic [31:0] TIMEOUT = 32'h0000_0000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [1:0]  host_mode,
   input  logic [63:0] host_addr,
   input  logic        host_go,
   input  logic        host_stop,
   input  logic        host_irq_ack,
   output logic        host_busy,
   output logic        host_irq,
   output logic        host_done,
   output logic        host_error,
   output logic        host_aborted,
   output logic [63:0] host_data,
   output logic [15:0] host_irq_count,
   output logic [1:0]  mode_mode,
   output logic        mode_start,
   output logic [63:0] mode_addr,
   input  logic        mode_end,
   input  logic [63:0] mode_data,
   input  logic        mode_irq,
   input  logic        mode_error,
   output logic        mode_ack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_IRQ,
      S_ACK
   } state_t;

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic        irq_q, irq_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        aborted_q, aborted_d;
   logic [63:0] data_q, data_d;
   logic [15:0] irq_count_q, irq_count_d;
   logic [1:0]  mode_q, mode_d;
   logic        start_q, start_d;
   logic [63:0] addr_q, addr_d;
   logic        ack_q, ack_d;
   logic [31:0] wdog_q, wdog_d;
   logic        timeout_hit;

   assign timeout_hit = (TIMEOUT != 32'd0) && (wdog_q == (TIMEOUT - 32'd1));

   always_comb begin
      state_d     = state_q;
      irq_d       = irq_q;
      done_d      = done_q;
      error_d     = error_q;
      aborted_d   = aborted_q;
      data_d      = data_q;
      irq_count_d = irq_count_q;
      mode_d      = mode_q;
      start_d     = start_q;
      addr_d      = addr_q;
      ack_d       = 1'b0;
      wdog_d      = wdog_q;

      case (state_q)
         S_IDLE: begin
            start_d = 1'b0;
            if (host_go) begin
               mode_d      = host_mode;
               addr_d      = host_addr;
               done_d      = 1'b0;
               error_d     = 1'b0;
               aborted_d   = 1'b0;
               irq_count_d = 16'd0;
               data_d      = 64'd0;
               wdog_d      = 32'd0;
               start_d     = 1'b1;
               state_d     = S_ARM;
            end
         end
         // The engine may still present the previous run's end flag here.
         S_ARM: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            wdog_d = wdog_q + 32'd1;
            if (host_stop) begin
               aborted_d = 1'b1;
               done_d    = 1'b1;
               start_d   = 1'b0;
               state_d   = S_IDLE;
            end else if (mode_error) begin
               error_d = 1'b1;
               done_d  = 1'b1;
               data_d  = mode_data;
               start_d = 1'b0;
               state_d = S_IDLE;
            end else if (mode_end) begin
               done_d  = 1'b1;
               data_d  = mode_data;
               start_d = 1'b0;
               state_d = S_IDLE;
            end else if (timeout_hit) begin
               error_d = 1'b1;
               done_d  = 1'b1;
               start_d = 1'b0;
               state_d = S_IDLE;
            end else if (mode_irq) begin
               data_d      = mode_data;
               irq_count_d = (irq_count_q == 16'hffff) ? irq_count_q : irq_count_q + 16'd1;
               irq_d       = 1'b1;
               state_d     = S_IRQ;
            end
         end
         S_IRQ: begin
            if (host_stop) begin
               irq_d     = 1'b0;
               aborted_d = 1'b1;
               done_d    = 1'b1;
               start_d   = 1'b0;
               state_d   = S_IDLE;
            end else if (host_irq_ack) begin
               irq_d   = 1'b0;
               ack_d   = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            state_d = S_RUN;
         end
         default: begin
            state_d = S_IDLE;
            start_d = 1'b0;
            irq_d   = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         irq_q       <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         aborted_q   <= 1'b0;
         data_q      <= 64'd0;
         irq_count_q <= 16'd0;
         mode_q      <= 2'd0;
         start_q     <= 1'b0;
         addr_q      <= 64'd0;
         ack_q       <= 1'b0;
         wdog_q      <= 32'd0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         irq_q       <= irq_d;
         done_q      <= done_d;
         error_q     <= error_d;
         aborted_q   <= aborted_d;
         data_q      <= data_d;
         irq_count_q <= irq_count_d;
         mode_q      <= mode_d;
         start_q     <= start_d;
         addr_q      <= addr_d;
         ack_q       <= ack_d;
         wdog_q      <= wdog_d;
      end
   end

   assign host_busy      = busy_q;
   assign host_irq       = irq_q;
   assign host_done      = done_q;
   assign host_error     = error_q;
   assign host_aborted   = aborted_q;
   assign host_data      = data_q;
   assign host_irq_count = irq_count_q;
   assign mode_mode      = mode_q;
   assign mode_start     = start_q;
   assign mode_addr      = addr_q;
   assign mode_ack       = ack_q;

endmodule

// File: tb/tb_checker_mode_ctrl.sv
// Randomized run-level bench for checker_mode_ctrl: an engine model plus
// per-run expectations derived from the interface rules.
module tb_checker_mode_ctrl;

   localparam logic [31:0] TO_LIMIT = 32'd10;
   localparam int K_END = 0, K_ERR = 1, K_ERR_END = 2, K_STOP_RUN = 3, K_STOP_IRQ = 4;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [1:0]  host_mode = 2'd0;
   logic [63:0] host_addr = 64'd0;
   logic        host_go = 1'b0, host_go_to = 1'b0, host_stop = 1'b0, host_irq_ack = 1'b0;
   logic        mode_end = 1'b0, mode_irq = 1'b0, mode_error = 1'b0;
   logic [63:0] mode_data = 64'd0;

   logic        host_busy, host_irq, host_done, host_error, host_aborted, mode_start, mode_ack;
   logic [63:0] host_data, mode_addr;
   logic [15:0] host_irq_count;
   logic [1:0]  mode_mode;

   logic        busy_to, irq_to, done_to, error_to, aborted_to, start_to, ack_to;
   logic [63:0] data_to, addr_to;
   logic [15:0] count_to;
   logic [1:0]  mode_to;

   int n_tests = 0, n_fail = 0;
   int irq_hi_cnt = 0, ack_cnt = 0;

   checker_mode_ctrl #(.TIMEOUT(32'd0)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .host_mode(host_mode), .host_addr(host_addr),
      .host_go(host_go), .host_stop(host_stop), .host_irq_ack(host_irq_ack),
      .host_busy(host_busy), .host_irq(host_irq), .host_done(host_done), .host_error(host_error),
      .host_aborted(host_aborted), .host_data(host_data), .host_irq_count(host_irq_count),
      .mode_mode(mode_mode), .mode_start(mode_start), .mode_addr(mode_addr),
      .mode_end(mode_end), .mode_data(mode_data), .mode_irq(mode_irq), .mode_error(mode_error),
      .mode_ack(mode_ack)
   );

   checker_mode_ctrl #(.TIMEOUT(TO_LIMIT)) dut_to (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .host_mode(host_mode), .host_addr(host_addr),
      .host_go(host_go_to), .host_stop(host_stop), .host_irq_ack(host_irq_ack),
      .host_busy(busy_to), .host_irq(irq_to), .host_done(done_to), .host_error(error_to),
      .host_aborted(aborted_to), .host_data(data_to), .host_irq_count(count_to),
      .mode_mode(mode_to), .mode_start(start_to), .mode_addr(addr_to),
      .mode_end(mode_end), .mode_data(mode_data), .mode_irq(mode_irq), .mode_error(mode_error),
      .mode_ack(ack_to)
   );

   always #5 sys_clk = ~sys_clk;

   // Level monitors for the main instance, sampled mid-cycle.
   always @(negedge sys_clk) begin
      if (host_irq) irq_hi_cnt++;
      if (mode_ack) ack_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: simulation still running, required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, host_busy, 0);
      check({tag, "_irq"}, host_irq, 0);
      check({tag, "_done"}, host_done, 0);
      check({tag, "_error"}, host_error, 0);
      check({tag, "_aborted"}, host_aborted, 0);
      check({tag, "_data"}, host_data, 0);
      check({tag, "_count"}, host_irq_count, 0);
      check({tag, "_mode"}, mode_mode, 0);
      check({tag, "_start"}, mode_start, 0);
      check({tag, "_addr"}, mode_addr, 0);
      check({tag, "_ack"}, mode_ack, 0);
   endtask

   // One complete run. The engine model ends with data = addr + number of irqs.
   task automatic do_run(input int id, input logic [1:0] m, input logic [63:0] a, input int kind,
                         input int nirq, input int dly, input bit keep_end);
      logic [63:0] exp_data, rnd;
      int hi0, ack0, exp_hi, exp_ack, d, gap;
      bit ended;
      hi0 = irq_hi_cnt; ack0 = ack_cnt; exp_hi = 0; exp_ack = 0; exp_data = 64'd0; ended = 0;
      $display("[TB] run %0d kind=%0d irqs=%0d mode=%0d addr=%h stale_end=%0d",
               id, kind, nirq, m, a, mode_end);
      host_mode = m; host_addr = a; host_go = 1'b1;
      step();
      host_go = 1'b0; host_mode = ~m; host_addr = ~a;
      check("go_start", mode_start, 1);
      check("go_busy", host_busy, 1);
      check("go_mode", mode_mode, m);
      check("go_addr", mode_addr, a);
      check("go_done_clr", host_done, 0);
      check("go_count_clr", host_irq_count, 0);
      check("go_data_clr", host_data, 0);
      step();
      mode_end = 1'b0;
      check("arm_hides_end", host_busy, 1);
      for (int i = 0; i < nirq && !ended; i++) begin
         gap = $urandom_range(0, 4);
         repeat (gap) begin
            host_go = 1'($urandom); host_irq_ack = 1'($urandom);
            step();
            host_go = 1'b0; host_irq_ack = 1'b0;
         end
         rnd = {$urandom, $urandom};
         mode_irq = 1'b1; mode_data = rnd;
         step();
         exp_data = rnd;
         check("irq_raise", host_irq, 1);
         check("irq_data", host_data, exp_data);
         check("irq_count", host_irq_count, 64'(i + 1));
         d = (dly != 0) ? dly : $urandom_range(1, 4);
         exp_hi += d;
         repeat (d - 1) step();
         if (kind == K_STOP_IRQ && i == nirq - 1) begin
            host_stop = 1'b1;
            step();
            host_stop = 1'b0; mode_irq = 1'b0;
            check("stop_irq_irq", host_irq, 0);
            check("stop_irq_ack", mode_ack, 0);
            ended = 1;
         end else begin
            host_irq_ack = 1'b1;
            step();
            host_irq_ack = 1'b0; mode_irq = 1'b0;
            exp_ack++;
            check("ack_pulse", mode_ack, 1);
            check("ack_irq_low", host_irq, 0);
            step();
            check("ack_done", mode_ack, 0);
            check("ack_resume", host_busy, 1);
         end
      end
      if (!ended) begin
         gap = $urandom_range(0, 3);
         repeat (gap) step();
         rnd = {$urandom, $urandom};
         case (kind)
            K_END: begin
               mode_end = 1'b1; mode_data = a + 64'(nirq); exp_data = a + 64'(nirq);
            end
            K_ERR, K_ERR_END: begin
               mode_error = 1'b1; mode_end = (kind == K_ERR_END); mode_data = rnd; exp_data = rnd;
            end
            default: begin
               host_stop = 1'b1; mode_data = rnd;
            end
         endcase
         step();
         host_stop = 1'b0; mode_error = 1'b0;
         if (!(kind == K_END && keep_end)) mode_end = 1'b0;
      end
      check("end_done", host_done, 1);
      check("end_busy", host_busy, 0);
      check("end_start", mode_start, 0);
      check("end_irq", host_irq, 0);
      check("end_error", host_error, (kind == K_ERR || kind == K_ERR_END) ? 1 : 0);
      check("end_aborted", host_aborted, (kind == K_STOP_RUN || kind == K_STOP_IRQ) ? 1 : 0);
      check("end_data", host_data, exp_data);
      check("end_count", host_irq_count, 64'(nirq));
      check("end_mode", mode_mode, m);
      check("end_addr", mode_addr, a);
      check("irq_high_cycles", 64'(irq_hi_cnt - hi0), 64'(exp_hi));
      check("ack_cycles", 64'(ack_cnt - ack0), 64'(exp_ack));
      if (!(kind == K_END && keep_end)) begin
         step();
         check("idle_done_sticky", host_done, 1);
         check("idle_busy", host_busy, 0);
      end
   endtask

   // Timeout instance: optionally takes one interrupt held for 4 cycles.
   task automatic timeout_run(input bit with_irq);
      int cyc;
      logic [63:0] rnd;
      rnd = {$urandom, $urandom};
      $display("[TB] timeout run with_irq=%0d", with_irq);
      host_go_to = 1'b1;
      step();
      host_go_to = 1'b0;
      cyc = 0;
      while (!error_to && cyc < 100) begin
         if (with_irq) begin
            if (cyc == 3) begin mode_irq = 1'b1; mode_data = rnd; end
            if (cyc == 7) host_irq_ack = 1'b1;
            if (cyc == 8) begin host_irq_ack = 1'b0; mode_irq = 1'b0; end
         end
         step();
         cyc++;
      end
      check("timeout_cycles", 64'(cyc), with_irq ? 64'(1 + TO_LIMIT + 4 + 1) : 64'(1 + TO_LIMIT));
      check("timeout_done", done_to, 1);
      check("timeout_busy", busy_to, 0);
      check("timeout_start", start_to, 0);
      check("timeout_aborted", aborted_to, 0);
      check("timeout_count", count_to, with_irq ? 1 : 0);
      check("timeout_data", data_to, with_irq ? rnd : 64'd0);
      step();
   endtask

   initial begin
      int kind, nirq;
      repeat (3) step();
      check_all_zero("reset");
      check("reset_to_busy", busy_to, 0);
      check("reset_to_start", start_to, 0);
      sys_rst = 1'b0;
      step();

      do_run(0, 2'd0, 64'd5, K_END, 0, 0, 1'b1);
      check("dummy_data_lsb", 64'(host_data[7:0]), 64'h05);
      do_run(1, 2'd1, {$urandom, $urandom}, K_END, 2, 3, 1'b0);
      do_run(2, 2'd2, {$urandom, $urandom}, K_ERR_END, 1, 0, 1'b0);
      do_run(3, 2'd3, {$urandom, $urandom}, K_STOP_IRQ, 1, 2, 1'b0);
      for (int r = 4; r < 28; r++) begin
         kind = $urandom_range(0, 4);
         nirq = $urandom_range(0, 3);
         if (kind == K_STOP_IRQ && nirq == 0) nirq = 1;
         do_run(r, 2'($urandom), {$urandom, $urandom}, kind, nirq, 0, 1'($urandom));
      end
      mode_end = 1'b0;
      step();

      $display("[TB] no-timeout run: 1000 cycles");
      host_go = 1'b1;
      step();
      host_go = 1'b0;
      repeat (1000) step();
      check("no_timeout_busy", host_busy, 1);
      check("no_timeout_done", host_done, 0);
      host_stop = 1'b1;
      step();
      host_stop = 1'b0;
      check("no_timeout_abort", host_aborted, 1);

      timeout_run(1'b0);
      timeout_run(1'b1);

      $display("[TB] reset during IRQ");
      host_addr = 64'h1234; host_mode = 2'd2; host_go = 1'b1;
      step();
      host_go = 1'b0;
      step();
      mode_irq = 1'b1; mode_data = 64'hdead_beef;
      step();
      check("pre_reset_irq", host_irq, 1);
      sys_rst = 1'b1;
      step();
      check_all_zero("irq_reset");
      sys_rst = 1'b0; mode_irq = 1'b0;
      step();
      check("post_reset_busy", host_busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/checker_mode_ctrl.md
# checker_mode_ctrl

Initiator side of the checker mode interface: drives `mode_mode`/`mode_start`/`mode_addr` into a checker mode engine, holds the run alive, relays engine interrupts to the host and acknowledges them, and captures end/error status and data. Sits between the checker CSR/host logic and the mode engines (dummy and real modes), so software runs a check with one go pulse and one ack per intermediate interrupt.

## Interface
- `TIMEOUT`, 32'h0000_0000: watchdog limit in RUN cycles without end; 0 disables.
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `host_mode` in 2: mode to run, sampled on `host_go`.
- `host_addr` in 64: mode argument, sampled on `host_go`.
- `host_go` in 1: one-cycle start pulse; ignored unless IDLE.
- `host_stop` in 1: one-cycle abort pulse; ignored in IDLE.
- `host_irq_ack` in 1: one-cycle ack of `host_irq`; ignored unless IRQ.
- `host_busy` out 1: high in every state except IDLE.
- `host_irq` out 1: high while in IRQ.
- `host_done` out 1: sticky, set on run completion (end, error, abort, timeout).
- `host_error` out 1: sticky, set with `host_done` on engine error or timeout.
- `host_aborted` out 1: sticky, set with `host_done` on `host_stop`.
- `host_data` out 64: `mode_data` captured at end or at interrupt entry.
- `host_irq_count` out 16: interrupts taken this run, saturating at 16'hffff.
- `mode_mode` out 2: registered copy of `host_mode`.
- `mode_start` out 1: held high for the whole run.
- `mode_addr` out 64: registered copy of `host_addr`.
- `mode_end` in 1, `mode_data` in 64, `mode_irq` in 1, `mode_error` in 1: engine status.
- `mode_ack` out 1: one-cycle interrupt acknowledge to the engine.

## Operation
- All outputs reset to 0; state IDLE; watchdog counter 0.
- States: IDLE, ARM, RUN, IRQ, ACK. All outputs registered.
- IDLE: `mode_start`=0. On `host_go`: latch mode/addr to `mode_mode`/`mode_addr`, clear `host_done`/`host_error`/`host_aborted`/`host_irq_count`/`host_data`, watchdog=0, `mode_start`<=1, go ARM.
- ARM: exactly one cycle; `mode_end`/`mode_error`/`mode_irq` ignored (engine still shows previous run's stale `mode_end`). Go RUN.
- RUN: watchdog increments each cycle. Priority per cycle: `host_stop` > `mode_error` > `mode_end` > timeout > `mode_irq`.
  - stop: `host_aborted`=1, `host_done`=1, `mode_start`=0, IDLE.
  - error: `host_error`=1, `host_done`=1, `host_data`<=`mode_data`, `mode_start`=0, IDLE.
  - end: `host_done`=1, `host_data`<=`mode_data`, `mode_start`=0, IDLE.
  - timeout (`TIMEOUT`!=0 and watchdog==`TIMEOUT`-1): `host_error`=1, `host_done`=1, `mode_start`=0, IDLE.
  - irq: `host_data`<=`mode_data`, `host_irq_count`+1 (saturating), `host_irq`=1, IRQ.
- IRQ: watchdog frozen, `mode_start` held. `host_stop` -> abort as in RUN (`host_irq`=0). Else `host_irq_ack` -> `host_irq`=0, `mode_ack`=1, ACK.
- ACK: one cycle, `mode_ack` high; engine errors/ends ignored; next cycle `mode_ack`=0, RUN.
- `host_go` outside IDLE and `host_irq_ack` outside IRQ have no effect.
- Reset in any state: immediate return to IDLE, `mode_start`/`mode_ack`/`host_irq` low next cycle, status cleared.

## Timing
- `host_go` at edge n -> `mode_start`, `mode_mode`, `mode_addr` valid after edge n; first engine status sampled at edge n+2.
- `mode_end` sampled high at edge e -> `host_done`=1, `host_busy`=0, `mode_start`=0 after edge e.
- `mode_irq` sampled at edge i -> `host_irq` after edge i; `host_irq_ack` at edge k -> `mode_ack` high for cycle k..k+1; RUN resumes sampling at edge k+2 (engine has cleared `mode_irq` by then).
- Back-to-back runs: `host_go` allowed in the cycle after `host_done` rises; ARM hides the stale `mode_end`.
- Watchdog: 32 bits, counts RUN cycles only, not ARM/IRQ/ACK.

## Test plan
- Dummy engine, `host_mode`=0, `host_addr`=5, `host_go` -> `host_done`=1, `host_error`=0, `host_data[7:0]`=8'h05, `host_irq_count`=0, `mode_start` low after end.
- Engine model raising `mode_irq` twice; host acks each after 3 cycles -> `host_irq` high 3 cycles each, `mode_ack` exactly 1 cycle each, `host_irq_count`=2, run completes.
- Second `host_go` 1 cycle after first `host_done` while engine holds stale `mode_end`=1 -> run not ended early; completes with correct data.
- `mode_error` and `mode_end` same cycle -> `host_done`=1, `host_error`=1; `host_stop` during IRQ -> `host_aborted`=1, `host_irq`=0, no `mode_ack`.
- `TIMEOUT`=10, engine never ends -> `host_error`=1 exactly 10 RUN cycles after ARM; `TIMEOUT`=0 -> no timeout after 1000 cycles.
- `sys_rst` asserted in IRQ -> next cycle all outputs 0, state IDLE; `host_go` ignored while busy.
